// File: rtl/line_clear_unit_if.sv
// line_clear_unit_if: controller <-> line-clear engine signal bundle.
// master = game controller, slave = line_clear_unit.
interface line_clear_unit_if #(
  parameter int ROWS = 20,
  parameter int COLS = 10
);
  logic                   clear_board;
  logic                   update_board_state;
  logic [ROWS*COLS-1:0]   merge_mask;
  logic                   shift_down;
  logic [ROWS*COLS-1:0]   board;
  logic [ROWS-1:0]        completed_lines;
  logic                   clear_busy;
  logic                   clear_done;

  modport master (
    output clear_board, update_board_state, merge_mask, shift_down,
    input  board, completed_lines, clear_busy, clear_done
  );

  modport slave (
    input  clear_board, update_board_state, merge_mask, shift_down,
    output board, completed_lines, clear_busy, clear_done
  );
endinterface

// File: rtl/line_clear_unit.sv
// line_clear_unit: settled-board register and line-clear engine.
// Merges landed pieces, reports full rows, and on shift_down removes every
// full row (bottom-most first), moving the rows above down one row per clock.
// Optional feature macro: LINE_CLEAR_SCORE_EN adds the 16-bit saturating
// lines_cleared counter output.
module line_clear_unit #(
  parameter int ROWS = 20,
  parameter int COLS = 10
) (
  input  logic                clock,
  input  logic                resetn,
  line_clear_unit_if.slave    bus
`ifdef LINE_CLEAR_SCORE_EN
  ,
  output logic [15:0]         lines_cleared
`endif
);

  localparam int PTR_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [COLS-1:0]    rows_q [ROWS];
  logic [COLS-1:0]    rows_d [ROWS];
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   full_idx;
  logic               any_full;

  // Board flattening, per-row full flags and bottom-most full row index.
  always_comb begin
    bus.board           = '0;
    bus.completed_lines = '0;
    full_idx            = '0;
    any_full            = 1'b0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      bus.board[r*COLS +: COLS] = rows_q[r];
      bus.completed_lines[r]    = &rows_q[r];
      if (&rows_q[r]) begin
        full_idx = PTR_W'(r);
        any_full = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state and status outputs.
  always_comb begin
    state_d        = state_q;
    bus.clear_busy = (state_q != IDLE);
    bus.clear_done = (state_q == DONE);
    if (bus.clear_board) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.shift_down && !bus.update_board_state) state_d = SCAN;
        SCAN:    state_d = any_full ? SHIFT : DONE;
        SHIFT:   if (ptr_q == '0) state_d = SCAN;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Board and row-pointer next values: merge, one-row shift, wipe.
  always_comb begin
    rows_d = rows_q;
    ptr_d  = ptr_q;
    if (bus.clear_board) begin
      for (int unsigned r = 0; r < ROWS; r++) rows_d[r] = '0;
      ptr_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.update_board_state) begin
            for (int unsigned r = 0; r < ROWS; r++)
              rows_d[r] = rows_q[r] | bus.merge_mask[r*COLS +: COLS];
          end
        end
        SCAN: begin
          if (any_full) ptr_d = full_idx;
        end
        SHIFT: begin
          if (ptr_q == '0) begin
            rows_d[0] = '0;
          end else begin
            for (int unsigned r = 1; r < ROWS; r++)
              if (ptr_q == PTR_W'(r)) rows_d[r] = rows_q[r-1];
            ptr_d = ptr_q - PTR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Board and pointer registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rows_q <= '{default: '0};
      ptr_q  <= '0;
    end else begin
      rows_q <= rows_d;
      ptr_q  <= ptr_d;
    end
  end

`ifdef LINE_CLEAR_SCORE_EN
  logic [15:0] score_q;

  // Rows-removed counter, one per SCAN->SHIFT, saturating.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                                         score_q <= '0;
    else if (bus.clear_board)                            score_q <= '0;
    else if (state_q == SCAN && any_full && score_q != '1) score_q <= score_q + 16'd1;
  end

  assign lines_cleared = score_q;
`endif

endmodule

// File: tb/tb_line_clear_unit.sv
// tb_line_clear_unit: directed bench for line_clear_unit with a row-level
// reference model and per-cycle output comparison.
module tb_line_clear_unit;

  localparam int ROWS = 20;
  localparam int COLS = 10;
  localparam int N    = ROWS * COLS;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  line_clear_unit_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

`ifdef LINE_CLEAR_SCORE_EN
  logic [15:0] lines_cleared;
`endif

  line_clear_unit #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clock         (clock),
    .resetn        (resetn),
    .bus           (bus)
`ifdef LINE_CLEAR_SCORE_EN
    ,
    .lines_cleared (lines_cleared)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int ecount   = 0;

  always @(posedge clock) ecount <= ecount + 1;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] row_mask(input int r, input logic [COLS-1:0] v);
    logic [N-1:0] m;
    m = '0;
    m[r*COLS +: COLS] = v;
    return m;
  endfunction

  // ---------------- reference model (row-level) ----------------
  function automatic int highest_full(input logic [N-1:0] b);
    for (int r = ROWS - 1; r >= 0; r--)
      if (b[r*COLS +: COLS] == {COLS{1'b1}}) return r;
    return -1;
  endfunction

  function automatic logic [N-1:0] drop_row(input logic [N-1:0] b, input int k);
    logic [N-1:0] nb;
    nb = b;
    for (int r = k; r >= 1; r--) nb[r*COLS +: COLS] = b[(r-1)*COLS +: COLS];
    nb[0 +: COLS] = '0;
    return nb;
  endfunction

  function automatic logic [N-1:0] settle(input logic [N-1:0] b);
    int k;
    for (int i = 0; i <= ROWS; i++) begin
      k = highest_full(b);
      if (k < 0) break;
      b = drop_row(b, k);
    end
    return b;
  endfunction

  // Edge offset from E0 of the clear_done cycle: 1 + sum(k_i + 2).
  function automatic int done_offset(input logic [N-1:0] b);
    int k, cost;
    cost = 1;
    for (int i = 0; i <= ROWS; i++) begin
      k = highest_full(b);
      if (k < 0) break;
      cost += k + 2;
      b = drop_row(b, k);
    end
    return cost;
  endfunction

  function automatic int rows_removed(input logic [N-1:0] b);
    int k, n;
    n = 0;
    for (int i = 0; i <= ROWS; i++) begin
      k = highest_full(b);
      if (k < 0) break;
      n++;
      b = drop_row(b, k);
    end
    return n;
  endfunction

  function automatic logic [ROWS-1:0] full_rows(input logic [N-1:0] b);
    logic [ROWS-1:0] c;
    for (int r = 0; r < ROWS; r++) c[r] = (b[r*COLS +: COLS] == {COLS{1'b1}});
    return c;
  endfunction

  logic [N-1:0] m_board;
  logic         m_busy;
  int           m_t, m_D;
  int           m_score;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_board <= '0; m_busy <= 1'b0; m_t <= 0; m_D <= 0; m_score <= 0;
    end else if (bus.clear_board) begin
      m_board <= '0; m_busy <= 1'b0; m_score <= 0;
    end else if (!m_busy) begin
      if (bus.update_board_state) m_board <= m_board | bus.merge_mask;
      else if (bus.shift_down) begin
        m_busy <= 1'b1; m_t <= 0; m_D <= done_offset(m_board);
      end
    end else if (m_t == m_D) begin
      m_busy  <= 1'b0;
      m_board <= settle(m_board);
      m_score <= (m_score + rows_removed(m_board) > 65535) ? 65535
                                                           : m_score + rows_removed(m_board);
    end else begin
      m_t <= m_t + 1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clock) begin
    check("cyc_busy", bus.clear_busy, m_busy);
    check("cyc_done", bus.clear_done, m_busy && (m_t == m_D));
    if (!m_busy) begin
      check("cyc_board", bus.board, m_board);
      check("cyc_completed", bus.completed_lines, full_rows(m_board));
`ifdef LINE_CLEAR_SCORE_EN
      check("cyc_score", lines_cleared, m_score[15:0]);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic merge(input logic [N-1:0] mask);
    bus.update_board_state = 1'b1;
    bus.merge_mask         = mask;
    @(negedge clock);
    bus.update_board_state = 1'b0;
    bus.merge_mask         = '0;
  endtask

  task automatic wipe();
    bus.clear_board = 1'b1;
    @(negedge clock);
    bus.clear_board = 1'b0;
  endtask

  task automatic run_clear(input string name, input int exp_edge);
    int e0, got;
    e0  = ecount + 1;
    got = -1;
    bus.shift_down = 1'b1;
    @(negedge clock);
    bus.shift_down = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.clear_done) begin
        got = ecount - e0;
        break;
      end
      @(negedge clock);
    end
    check(name, got, exp_edge);
    @(negedge clock);
  endtask

  task automatic wait_idle(input string name);
    int ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (!bus.clear_busy) begin ok = 1; break; end
      @(negedge clock);
    end
    check(name, ok, 1);
  endtask

  int dones;

  initial begin
    bus.clear_board        = 1'b0;
    bus.update_board_state = 1'b0;
    bus.merge_mask         = '0;
    bus.shift_down         = 1'b0;

    repeat (3) @(negedge clock);
    check("rst_board", bus.board, '0);
    check("rst_completed", bus.completed_lines, '0);
    check("rst_busy", bus.clear_busy, 1'b0);
    resetn = 1'b1;
    @(negedge clock);

    // Empty board: done during E1..E2.
    run_clear("empty_done_edge", 1);
    check("empty_board", bus.board, '0);

    // Row 19 full plus row 18 col 0.
    merge(row_mask(19, '1) | row_mask(18, 10'b1));
    run_clear("one_row_done_edge", 22);
    check("one_row_board", bus.board, row_mask(19, 10'b1));
`ifdef LINE_CLEAR_SCORE_EN
    check("one_row_score", lines_cleared, 16'd1);
`endif

    // Rows 18 and 19 full: two passes at k=19.
    wipe();
    merge(row_mask(18, '1) | row_mask(19, '1));
    run_clear("two_row_done_edge", 43);
    check("two_row_board", bus.board, '0);
`ifdef LINE_CLEAR_SCORE_EN
    check("two_row_score", lines_cleared, 16'd2);
`endif

    // Merge and shift_down together: merge wins, no pass.
    bus.update_board_state = 1'b1;
    bus.merge_mask         = row_mask(5, '1);
    bus.shift_down         = 1'b1;
    @(negedge clock);
    bus.update_board_state = 1'b0;
    bus.merge_mask         = '0;
    bus.shift_down         = 1'b0;
    check("both_busy", bus.clear_busy, 1'b0);
    check("both_completed", bus.completed_lines, 20'h00020);
    repeat (2) @(negedge clock);

    // Top row only: k=0 -> done at E3; rows below untouched.
    wipe();
    merge(row_mask(0, '1) | row_mask(3, 10'h155));
    run_clear("top_row_done_edge", 3);
    check("top_row_board", bus.board, row_mask(3, 10'h155));

    // Rows 0 and 19: k=19 then k=1 -> 1+21+3.
    wipe();
    merge(row_mask(0, '1) | row_mask(19, '1));
    run_clear("top_bottom_done_edge", 25);
    check("top_bottom_board", bus.board, '0);

    // Strobes during SHIFT are ignored.
    wipe();
    merge(row_mask(19, '1) | row_mask(10, 10'h3));
    bus.shift_down = 1'b1;
    @(negedge clock);
    bus.shift_down = 1'b0;
    repeat (4) @(negedge clock);
    bus.update_board_state = 1'b1;
    bus.merge_mask         = row_mask(2, '1);
    bus.shift_down         = 1'b1;
    @(negedge clock);
    bus.update_board_state = 1'b0;
    bus.merge_mask         = '0;
    bus.shift_down         = 1'b0;
    wait_idle("ignore_idle_timeout");
    check("ignore_board", bus.board, row_mask(11, 10'h3));
    repeat (2) @(negedge clock);

    // clear_board mid-SHIFT: immediate idle, empty, no done pulse.
    merge(row_mask(19, '1));
    bus.shift_down = 1'b1;
    @(negedge clock);
    bus.shift_down = 1'b0;
    repeat (4) @(negedge clock);
    bus.clear_board = 1'b1;
    @(negedge clock);
    bus.clear_board = 1'b0;
    check("wipe_board", bus.board, '0);
    check("wipe_busy", bus.clear_busy, 1'b0);
    check("wipe_done", bus.clear_done, 1'b0);
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.clear_done) dones++;
      @(negedge clock);
    end
    check("wipe_no_done", dones, 0);

    // Short asynchronous reset pulse mid-SHIFT.
    merge(row_mask(19, '1) | row_mask(4, 10'h0F0));
    bus.shift_down = 1'b1;
    @(negedge clock);
    bus.shift_down = 1'b0;
    repeat (4) @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    check("arst_board", bus.board, '0);
    check("arst_completed", bus.completed_lines, '0);
    check("arst_busy", bus.clear_busy, 1'b0);
    check("arst_done", bus.clear_done, 1'b0);
    #1 resetn = 1'b1;
    @(negedge clock);

    // Engine still works after the aborted pass.
    merge(row_mask(19, '1));
    run_clear("post_rst_done_edge", 22);
    check("post_rst_board", bus.board, '0);
    repeat (2) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/line_clear_unit.md
# line_clear_unit

Board-state register and line-clear engine for the Tetris datapath. Holds the settled playfield (pieces that have landed), merges each landed piece into it, and reports which rows are full. On command it removes every full row, shifting the rows above down one row per clock, and signals completion. The game controller drives it with its update-board and line-check strobes and consumes its completed-lines vector and done pulse.

## Interface

- ROWS, 20, playfield height; row 0 is top, row ROWS-1 is bottom.
- COLS, 10, playfield width.
- clock  in  1  sole clock; all state updates on posedge.
- resetn  in  1  asynchronous, active-low reset.
- clear_board  in  1  synchronous board wipe for a new game; highest priority.
- update_board_state  in  1  one-cycle strobe: OR merge_mask into the board.
- merge_mask  in  ROWS*COLS  landed-piece cells; row r occupies bits [r*COLS +: COLS].
- shift_down  in  1  one-cycle strobe: start a clear pass.
- board  out  ROWS*COLS  settled board, same packing as merge_mask.
- completed_lines  out  ROWS  bit r = 1 when every cell of row r is set.
- clear_busy  out  1  high whenever the FSM is not in IDLE.
- clear_done  out  1  one-cycle pulse when a clear pass ends.

## Operation

- completed_lines is combinational from the board register: the AND-reduction of each row.
- FSM states:
  - IDLE
  - SCAN
  - SHIFT
  - DONE
- IDLE:
  - update_board_state: board <= board | merge_mask.
  - shift_down (without update_board_state): go to SCAN.
  - Both asserted together: the merge is applied and shift_down is ignored.
- SCAN:
  - If completed_lines != 0: ptr <= index of the highest-numbered (lowest on screen) full row k; go to SHIFT.
  - Otherwise go to DONE.
- SHIFT, one row per cycle:
  - ptr > 0: row[ptr] <= row[ptr-1]; ptr <= ptr-1.
  - ptr == 0: row[0] <= 0; go to SCAN.
- DONE: clear_done = 1 for this cycle only; go to IDLE.
- update_board_state and shift_down outside IDLE are ignored; they are not queued.
- clear_board in any state: board <= 0, ptr <= 0, next state IDLE. No clear_done is emitted.
- ptr width: $clog2(ROWS). Row indices never exceed ROWS-1.

## Timing

- Reset (resetn low, asynchronous) forces the following values:
  - board = 0, so completed_lines = 0.
  - clear_busy = 0, clear_done = 0.
  - ptr = 0, state = IDLE.
- Merge latency: board and completed_lines reflect the merge in the cycle after the strobe edge.
- shift_down sampled at edge E0:
  - clear_busy rises after E0.
  - Each removed row at index k costs 1 SCAN cycle plus k+1 SHIFT cycles.
  - The final SCAN and DONE cost 1 cycle each.
- clear_done is high during the cycle starting at E(1 + Σ(k_i + 2)), taken over the rows removed in order.
  - No full rows: clear_done is high during E1..E2.
- clear_busy falls at the same edge that ends clear_done.
- The controller holds in its line-check phase until clear_done.
- resetn asserted mid-pass aborts the pass immediately. The board keeps no partial-shift state; it is zeroed.

## Configuration

- LINE_CLEAR_SCORE_EN defined:
  - Adds output lines_cleared (16 bits), a count of rows removed, incremented once per SCAN→SHIFT transition.
  - The count saturates at 16'hFFFF.
  - It is zeroed by resetn and by clear_board.
- LINE_CLEAR_SCORE_EN undefined: the port and its counter are absent; all other behaviour is identical.

## Test plan

- Reset then idle: board = 0, completed_lines = 0, clear_busy = 0. shift_down at E0 → clear_done high E1..E2, board unchanged.
- Row 19 full plus one cell at row 18, column 0; shift_down at E0:
  - clear_done high in the cycle starting at E22.
  - Final board: row 19 holds only column 0, rows 0–18 are 0.
  - lines_cleared = 1 when LINE_CLEAR_SCORE_EN is defined.
- Rows 18 and 19 both full, shift_down at E0:
  - Two passes at k = 19.
  - clear_done at E43; board all zero.
- update_board_state with merge_mask = all of row 5, in the same cycle as shift_down: the merge is applied, no clear starts, and completed_lines[5] = 1 next cycle.
- clear_board asserted during SHIFT: the next cycle has board = 0, clear_busy = 0, and no clear_done pulse. update_board_state and shift_down asserted during SHIFT have no effect.
- resetn pulsed low for less than one clock period mid-SHIFT: outputs go to reset values asynchronously, before the next clock edge.
